led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_seq_pkg.sv | 41 ++++
 rtl/tick_phase_timer.sv | 36 +++
 rtl/led_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: command modes, FSM states and
// small state-decode helpers used by the top level.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SOLID    = 3'd1,
    ST_BLINK_HI = 3'd2,
    ST_BLINK_LO = 3'd3,
    ST_BURST_HI = 3'd4,
    ST_BURST_LO = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  // States whose duration is measured in tick pulses.
  function automatic logic is_timed(state_e s);
    return (s == ST_BLINK_HI) || (s == ST_BLINK_LO) ||
           (s == ST_BURST_HI) || (s == ST_BURST_LO);
  endfunction

  function automatic logic led_on(state_e s);
    return (s == ST_SOLID) || (s == ST_BLINK_HI) || (s == ST_BURST_HI);
  endfunction

  function automatic logic is_busy(state_e s);
    return is_timed(s) || (s == ST_DONE);
  endfunction

  function automatic logic can_accept(state_e s);
    return (s == ST_IDLE) || (s == ST_SOLID) ||
           (s == ST_BLINK_HI) || (s == ST_BLINK_LO);
  endfunction

endpackage

// File: rtl/tick_phase_timer.sv
// Counts tick pulses within one phase; phase_end flags the tick that
// completes a phase of `period` ticks and the counter restarts itself.
module tick_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             phase_end
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clear wins over a coincident tick, so that tick never ends a phase.
  assign phase_end = tick && !clear && (cnt_q == (period - CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear || phase_end) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED sequencer: OFF / ON / continuous BLINK / counted BURST driven by an
// external tick timebase, with a valid/ready command port.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_period,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             led,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             led_d, busy_d, done_d, ready_d;
  logic             accept;
  logic             clear;
  logic             phase_end;

  assign accept = cmd_valid && cmd_ready;
  assign clear  = accept || !is_timed(state_q);

  tick_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .clear     (clear),
    .period    (period_q),
    .phase_end (phase_end)
  );

  // Next state; an accepted command overrides any phase change this cycle.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    rem_d    = rem_q;
    if (accept) begin
      period_d = (cmd_period == '0) ? CNT_W'(1) : cmd_period;
      rem_d    = cmd_count;
      unique case (mode_e'(cmd_mode))
        MODE_OFF:   state_d = ST_IDLE;
        MODE_ON:    state_d = ST_SOLID;
        MODE_BLINK: state_d = ST_BLINK_HI;
        MODE_BURST: state_d = (cmd_count == '0) ? ST_DONE : ST_BURST_HI;
      endcase
    end else begin
      case (state_q)
        ST_IDLE, ST_SOLID: ;
        ST_BLINK_HI: if (phase_end) state_d = ST_BLINK_LO;
        ST_BLINK_LO: if (phase_end) state_d = ST_BLINK_HI;
        ST_BURST_HI: begin
          if (phase_end) begin
            state_d = ST_BURST_LO;
            rem_d   = rem_q - CNT_W'(1);
          end
        end
        ST_BURST_LO: if (phase_end) state_d = (rem_q == '0) ? ST_DONE : ST_BURST_HI;
        ST_DONE:     state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
    led_d   = led_on(state_d);
    busy_d  = is_busy(state_d);
    done_d  = (state_d == ST_DONE);
    ready_d = can_accept(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      period_q  <= '0;
      rem_q     <= '0;
      led       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      rem_q     <= rem_d;
      led       <= led_d;
      busy      <= busy_d;
      done      <= done_d;
      cmd_ready <= ready_d;
    end
  end

endmodule
